// File: rtl/candidategen_sweep_ctrl.sv
// Sweep controller for the candidate-row generator: loads an initial hard-decision
// vector, then issues one generator job per (j, a != x[j]) pair, j-major, a-minor.

module candidategen_sweep_ctrl #(
  parameter  int J       = 14,
  parameter  int A       = 2,
  parameter  int TIMEOUT = 4096,
  localparam int AWIDTH  = $clog2(A) + 1,
  localparam int J_WIDTH = $clog2(J) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [J*AWIDTH-1:0]   cfg_x_initial,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic                  abort,
  input  logic                  sink_ready,
  output logic [J*AWIDTH-1:0]   gen_x_initial,
  output logic                  gen_x_initial_tvalid,
  output logic                  gen_start,
  output logic [J_WIDTH-1:0]    gen_j_index,
  output logic [AWIDTH-1:0]     gen_a_value,
  input  logic                  gen_row_tvalid,
  input  logic                  gen_row_tlast,
  output logic [15:0]           job_rows,
  output logic [15:0]           job_cnt,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  err_timeout
);

  localparam int                  XW       = J * AWIDTH;
  localparam int                  TW       = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]       TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [J_WIDTH-1:0]  J_END    = J_WIDTH'(J);
  localparam logic [AWIDTH-1:0]   A_MAX    = AWIDTH'(A - 1);
  localparam logic [AWIDTH-1:0]   A_LIM    = AWIDTH'(A);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEEK,
    S_ISSUE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic              cfg_ready_q, cfg_ready_d;
  logic              cfg_err_q, cfg_err_d;
  logic [XW-1:0]     gen_x_q, gen_x_d;
  logic              gen_xtv_q, gen_xtv_d;
  logic              gen_start_q, gen_start_d;
  logic [J_WIDTH-1:0] gen_j_q, gen_j_d;
  logic [AWIDTH-1:0] gen_a_q, gen_a_d;
  logic [15:0]       job_rows_q, job_rows_d;
  logic [15:0]       job_cnt_q, job_cnt_d;
  logic              busy_q, busy_d;
  logic              sweep_done_q, sweep_done_d;
  logic              err_timeout_q, err_timeout_d;

  logic [J_WIDTH-1:0] j_q, j_d;
  logic [AWIDTH-1:0] a_q, a_d;
  logic [15:0]       row_cnt_q, row_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              prev_tvalid_q, prev_tvalid_d;
  logic              drain_q, drain_d;

  logic              cfg_fire;
  logic              cfg_bad;
  logic [AWIDTH-1:0] cur_sym;
  logic [J_WIDTH-1:0] j_adv;
  logic [AWIDTH-1:0] a_adv;
  logic              j_end;
  logic              pair_skip;
  logic              job_end;
  logic              tmo_hit;

  // tlast is observational only; a job ends on the tvalid falling edge.
  logic              unused_tlast;
  assign unused_tlast = gen_row_tlast;

  assign cfg_fire  = (state_q == S_IDLE) && cfg_valid;
  assign j_end     = (j_q >= J_END);
  assign pair_skip = (cur_sym == a_q);
  assign job_end   = (state_q == S_STREAM) && prev_tvalid_q && !gen_row_tvalid;
  assign tmo_hit   = (state_q == S_STREAM) && !job_end && (tmo_q == TMO_LAST);

  always_comb begin
    cfg_bad = 1'b0;
    for (int k = 0; k < J; k++) begin
      if (cfg_x_initial[k*AWIDTH +: AWIDTH] >= A_LIM) cfg_bad = 1'b1;
    end
  end

  always_comb begin
    cur_sym = '0;
    for (int k = 0; k < J; k++) begin
      if (j_q == J_WIDTH'(k)) cur_sym = gen_x_q[k*AWIDTH +: AWIDTH];
    end
  end

  // Pair iterator: a is the inner loop, wrapping into the next position j.
  always_comb begin
    a_adv = a_q + 1'b1;
    j_adv = j_q;
    if (a_q >= A_MAX) begin
      a_adv = '0;
      j_adv = j_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_fire && !cfg_bad) state_d = S_LOAD;
      S_LOAD:   state_d = abort ? S_IDLE : S_SEEK;
      S_SEEK: begin
        if (abort)           state_d = S_IDLE;
        else if (j_end)      state_d = S_DONE;
        else if (!pair_skip) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)           state_d = S_IDLE;
        else if (sink_ready) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (abort || tmo_hit) state_d = S_DRAIN;
        else if (job_end)     state_d = S_SEEK;
      end
      S_DRAIN:  if (!gen_row_tvalid && drain_q) state_d = S_IDLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next-state decode, so they line up with state_q.
  always_comb begin
    cfg_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    gen_xtv_d     = (state_d == S_LOAD);
    sweep_done_d  = (state_d == S_DONE);
    cfg_err_d     = cfg_fire && cfg_bad;
    gen_start_d   = 1'b0;
    gen_x_d       = gen_x_q;
    gen_j_d       = gen_j_q;
    gen_a_d       = gen_a_q;
    job_rows_d    = job_rows_q;
    job_cnt_d     = job_cnt_q;
    err_timeout_d = err_timeout_q;
    j_d           = j_q;
    a_d           = a_q;
    row_cnt_d     = row_cnt_q;
    tmo_d         = tmo_q;
    prev_tvalid_d = prev_tvalid_q;
    drain_d       = drain_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_fire && !cfg_bad) begin
          gen_x_d       = cfg_x_initial;
          job_cnt_d     = '0;
          err_timeout_d = 1'b0;
          j_d           = '0;
          a_d           = '0;
        end
      end
      S_SEEK: begin
        if (!abort && !j_end && pair_skip) begin
          j_d = j_adv;
          a_d = a_adv;
        end
      end
      S_ISSUE: begin
        if (!abort && sink_ready) begin
          gen_start_d   = 1'b1;
          gen_j_d       = j_q;
          gen_a_d       = a_q;
          row_cnt_d     = '0;
          tmo_d         = '0;
          prev_tvalid_d = 1'b0;
        end
      end
      S_STREAM: begin
        prev_tvalid_d = gen_row_tvalid;
        drain_d       = 1'b0;
        if (gen_row_tvalid && (row_cnt_q != 16'hFFFF)) row_cnt_d = row_cnt_q + 16'd1;
        if (!tmo_hit) tmo_d = tmo_q + 1'b1;
        if (tmo_hit) err_timeout_d = 1'b1;
        // Completion is honoured even when abort wins the state transition.
        if (job_end) begin
          job_rows_d = row_cnt_q;
          if (job_cnt_q != 16'hFFFF) job_cnt_d = job_cnt_q + 16'd1;
          j_d = j_adv;
          a_d = a_adv;
        end
      end
      S_DRAIN: drain_d = !gen_row_tvalid;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q   <= 1'b1;
      cfg_err_q     <= 1'b0;
      gen_x_q       <= '0;
      gen_xtv_q     <= 1'b0;
      gen_start_q   <= 1'b0;
      gen_j_q       <= '0;
      gen_a_q       <= '0;
      job_rows_q    <= '0;
      job_cnt_q     <= '0;
      busy_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      j_q           <= '0;
      a_q           <= '0;
      row_cnt_q     <= '0;
      tmo_q         <= '0;
      prev_tvalid_q <= 1'b0;
      drain_q       <= 1'b0;
    end else begin
      cfg_ready_q   <= cfg_ready_d;
      cfg_err_q     <= cfg_err_d;
      gen_x_q       <= gen_x_d;
      gen_xtv_q     <= gen_xtv_d;
      gen_start_q   <= gen_start_d;
      gen_j_q       <= gen_j_d;
      gen_a_q       <= gen_a_d;
      job_rows_q    <= job_rows_d;
      job_cnt_q     <= job_cnt_d;
      busy_q        <= busy_d;
      sweep_done_q  <= sweep_done_d;
      err_timeout_q <= err_timeout_d;
      j_q           <= j_d;
      a_q           <= a_d;
      row_cnt_q     <= row_cnt_d;
      tmo_q         <= tmo_d;
      prev_tvalid_q <= prev_tvalid_d;
      drain_q       <= drain_d;
    end
  end

  assign cfg_ready            = cfg_ready_q;
  assign cfg_err              = cfg_err_q;
  assign gen_x_initial        = gen_x_q;
  assign gen_x_initial_tvalid = gen_xtv_q;
  assign gen_start            = gen_start_q;
  assign gen_j_index          = gen_j_q;
  assign gen_a_value          = gen_a_q;
  assign job_rows             = job_rows_q;
  assign job_cnt              = job_cnt_q;
  assign busy                 = busy_q;
  assign sweep_done           = sweep_done_q;
  assign err_timeout          = err_timeout_q;

endmodule

// File: tb/tb_candidategen_sweep_ctrl.sv
// Directed bench for candidategen_sweep_ctrl with J=4, A=3, TIMEOUT=16: a vector
// table of full sweeps plus hand sequences for backpressure, abort, timeout and reset.

module tb_candidategen_sweep_ctrl;

  localparam int J       = 4;
  localparam int A       = 3;
  localparam int TIMEOUT = 16;
  localparam int AW      = 3;
  localparam int JW      = 3;
  localparam int XW      = J * AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [XW-1:0] cfg_x_initial;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic          abort;
  logic          sink_ready;
  logic [XW-1:0] gen_x_initial;
  logic          gen_x_initial_tvalid;
  logic          gen_start;
  logic [JW-1:0] gen_j_index;
  logic [AW-1:0] gen_a_value;
  logic          gen_row_tvalid;
  logic          gen_row_tlast;
  logic [15:0]   job_rows;
  logic [15:0]   job_cnt;
  logic          busy;
  logic          sweep_done;
  logic          err_timeout;

  candidategen_sweep_ctrl #(.J(J), .A(A), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_x_initial        (cfg_x_initial),
    .cfg_valid            (cfg_valid),
    .cfg_ready            (cfg_ready),
    .cfg_err              (cfg_err),
    .abort                (abort),
    .sink_ready           (sink_ready),
    .gen_x_initial        (gen_x_initial),
    .gen_x_initial_tvalid (gen_x_initial_tvalid),
    .gen_start            (gen_start),
    .gen_j_index          (gen_j_index),
    .gen_a_value          (gen_a_value),
    .gen_row_tvalid       (gen_row_tvalid),
    .gen_row_tlast        (gen_row_tlast),
    .job_rows             (job_rows),
    .job_cnt              (job_cnt),
    .busy                 (busy),
    .sweep_done           (sweep_done),
    .err_timeout          (err_timeout)
  );

  always #5 clk = ~clk;

  // Expected pairs are packed one byte per job, {j, a} as hex nibbles, first job in the MSB.
  typedef struct {
    logic [XW-1:0] x;
    bit            valid;
    int            rows;
    bit            no_last;
    logic [63:0]   pairs;
  } vec_t;

  vec_t vecs[6];

  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  n_start, n_done, n_err, n_load, last_high_cyc;
  int  st_j[32];
  int  st_a[32];

  int  gen_rows = 5;
  bit  gen_stuck = 1'b0;
  bit  gen_no_last = 1'b0;

  function automatic logic [XW-1:0] mkx(input logic [AW-1:0] s0, input logic [AW-1:0] s1,
                                        input logic [AW-1:0] s2, input logic [AW-1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  // Generator model: on gen_start, drive gen_rows rows (or hold tvalid while stuck).
  initial begin : gen_model
    int r;
    gen_row_tvalid = 1'b0;
    gen_row_tlast  = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_start) begin
        r = 0;
        while ((r < gen_rows || gen_stuck) && r < 2000) begin
          gen_row_tvalid = 1'b1;
          gen_row_tlast  = !gen_no_last && !gen_stuck && (r == gen_rows - 1);
          @(negedge clk);
          r++;
        end
        gen_row_tvalid = 1'b0;
        gen_row_tlast  = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearMon();
    n_start = 0;
    n_done  = 0;
    n_err   = 0;
    n_load  = 0;
    last_high_cyc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gen_start) begin
      if (n_start < 32) begin
        st_j[n_start] = int'(gen_j_index);
        st_a[n_start] = int'(gen_a_value);
      end
      n_start++;
    end
    if (sweep_done)           n_done++;
    if (cfg_err)              n_err++;
    if (gen_x_initial_tvalid) n_load++;
    if (gen_row_tvalid)       last_high_cyc = cyc;
  endtask

  task automatic waitIdle(input string name, input int bound);
    int k;
    k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    checkOutput({name, "_idle"}, busy, 0);
  endtask

  task automatic waitStarts(input string name, input int n, input int bound);
    int k;
    k = 0;
    while (n_start < n && k < bound) begin
      tick();
      k++;
    end
    checkOutput({name, "_starts"}, n_start, n);
  endtask

  task automatic fireCfg(input logic [XW-1:0] x);
    cfg_x_initial = x;
    cfg_valid     = 1'b1;
    tick();
    cfg_valid     = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearMon();
    gen_rows    = v.rows;
    gen_no_last = v.no_last;
    fireCfg(v.x);
    if (v.valid) waitIdle("sweep", 400);
    else repeat (4) tick();
  endtask

  initial begin : main
    logic [XW-1:0] last_x;
    int            start_c;
    int            k;

    vecs[0] = '{x: mkx(0, 0, 0, 0), valid: 1'b1, rows: 5, no_last: 1'b0, pairs: 64'h01_02_11_12_21_22_31_32};
    vecs[1] = '{x: mkx(2, 1, 0, 2), valid: 1'b1, rows: 3, no_last: 1'b0, pairs: 64'h00_01_10_12_21_22_30_31};
    vecs[2] = '{x: mkx(0, 3, 0, 0), valid: 1'b0, rows: 5, no_last: 1'b0, pairs: 64'h0};
    vecs[3] = '{x: mkx(1, 1, 1, 1), valid: 1'b1, rows: 1, no_last: 1'b1, pairs: 64'h00_02_10_12_20_22_30_32};
    vecs[4] = '{x: mkx(7, 0, 0, 4), valid: 1'b0, rows: 5, no_last: 1'b0, pairs: 64'h0};
    vecs[5] = '{x: mkx(0, 2, 1, 0), valid: 1'b1, rows: 2, no_last: 1'b0, pairs: 64'h01_02_10_11_20_22_31_32};

    rst_n = 1'b0;
    cfg_x_initial = '0;
    cfg_valid = 1'b0;
    abort = 1'b0;
    sink_ready = 1'b1;
    clearMon();
    repeat (3) @(negedge clk);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_job_cnt", job_cnt, 0);
    checkOutput("rst_gen_start", gen_start, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_cfg_ready", cfg_ready, 1);
    checkOutput("idle_sweep_done", sweep_done, 0);

    last_x = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].valid) begin
        last_x = vecs[i].x;
        checkOutput($sformatf("v%0d_starts", i), n_start, 8);
        for (int p = 0; p < 8; p++) begin
          k = int'(vecs[i].pairs[63 - 8*p -: 8]);
          checkOutput($sformatf("v%0d_pair%0d", i, p), st_j[p] * 16 + st_a[p], k);
        end
        checkOutput($sformatf("v%0d_job_cnt", i), job_cnt, 8);
        checkOutput($sformatf("v%0d_job_rows", i), job_rows, vecs[i].rows);
        checkOutput($sformatf("v%0d_done", i), n_done, 1);
        checkOutput($sformatf("v%0d_load", i), n_load, 1);
        checkOutput($sformatf("v%0d_err_timeout", i), err_timeout, 0);
      end else begin
        checkOutput($sformatf("v%0d_cfg_err", i), n_err, 1);
        checkOutput($sformatf("v%0d_busy", i), busy, 0);
        checkOutput($sformatf("v%0d_load", i), n_load, 0);
        checkOutput($sformatf("v%0d_starts", i), n_start, 0);
      end
      checkOutput($sformatf("v%0d_gen_x", i), gen_x_initial, last_x);
      checkOutput($sformatf("v%0d_cfg_ready", i), cfg_ready, 1);
    end

    // Backpressure in ISSUE, with a stray cfg_valid that must be ignored.
    clearMon();
    gen_rows = 2;
    gen_no_last = 1'b0;
    sink_ready = 1'b0;
    fireCfg(mkx(0, 0, 0, 0));
    repeat (3) tick();
    cfg_x_initial = mkx(1, 1, 1, 1);
    cfg_valid = 1'b1;
    repeat (17) tick();
    cfg_valid = 1'b0;
    checkOutput("bp_no_start", n_start, 0);
    checkOutput("bp_busy", busy, 1);
    checkOutput("bp_gen_x_kept", gen_x_initial, mkx(0, 0, 0, 0));
    checkOutput("bp_single_load", n_load, 1);
    sink_ready = 1'b1;
    tick();
    checkOutput("bp_start_next_cycle", n_start, 1);
    checkOutput("bp_j", gen_j_index, 0);
    checkOutput("bp_a", gen_a_value, 1);
    waitIdle("bp", 400);
    checkOutput("bp_total_starts", n_start, 8);
    checkOutput("bp_done", n_done, 1);

    // Abort while the third job is mid-stream.
    clearMon();
    gen_rows = 5;
    fireCfg(mkx(0, 0, 0, 0));
    waitStarts("ab", 3, 200);
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    waitIdle("ab", 100);
    checkOutput("ab_drain_exit", cyc - last_high_cyc, 2);
    checkOutput("ab_starts", n_start, 3);
    checkOutput("ab_job_cnt", job_cnt, 2);
    checkOutput("ab_done", n_done, 0);

    // Abort in the very cycle the third job completes: completion still counts.
    clearMon();
    fireCfg(mkx(0, 0, 0, 0));
    waitStarts("abc", 3, 200);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    waitIdle("abc", 100);
    checkOutput("abc_starts", n_start, 3);
    checkOutput("abc_job_cnt", job_cnt, 3);
    checkOutput("abc_job_rows", job_rows, 5);
    checkOutput("abc_done", n_done, 0);

    // Stuck generator: timeout, drain, then a new cfg clears the sticky flag.
    clearMon();
    gen_stuck = 1'b1;
    gen_rows = 1;
    fireCfg(mkx(0, 0, 0, 0));
    waitStarts("to", 1, 20);
    start_c = cyc;
    k = 0;
    while (!err_timeout && k < 40) begin
      tick();
      k++;
    end
    checkOutput("to_latency", cyc - start_c, TIMEOUT);
    repeat (5) tick();
    checkOutput("to_drain_busy", busy, 1);
    checkOutput("to_starts", n_start, 1);
    gen_stuck = 1'b0;
    waitIdle("to", 50);
    checkOutput("to_sticky", err_timeout, 1);
    checkOutput("to_done", n_done, 0);
    clearMon();
    gen_rows = 2;
    fireCfg(mkx(2, 1, 0, 2));
    checkOutput("to_cleared", err_timeout, 0);
    waitIdle("to_resweep", 400);
    checkOutput("to_resweep_cnt", job_cnt, 8);

    // Asynchronous reset in the middle of a stream.
    clearMon();
    gen_rows = 5;
    fireCfg(mkx(2, 1, 0, 2));
    waitStarts("rs", 2, 200);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rs_busy", busy, 0);
    checkOutput("rs_cfg_ready", cfg_ready, 1);
    checkOutput("rs_job_cnt", job_cnt, 0);
    checkOutput("rs_job_rows", job_rows, 0);
    checkOutput("rs_gen_x", gen_x_initial, 0);
    checkOutput("rs_gen_start", gen_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clearMon();
    repeat (10) tick();
    checkOutput("rs_stay_idle", busy, 0);
    checkOutput("rs_no_start", n_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/candidategen_sweep_ctrl.md
Name: candidategen_sweep_ctrl

Overview:
Sequences a full single-symbol sweep over the candidate-row generator. It accepts an initial hard-decision vector and loads it into the generator. It then issues one generator job per (position j, symbol value a) pair where a differs from the initial symbol, and waits for each job's row stream to finish before issuing the next. It sits between the detector's configuration path and the candidate generator, and gates job issue on downstream readiness.

Parameters:
J, 14, number of symbol positions per row
A, 2, alphabet size; legal symbol values are 0..A-1
AWIDTH, $clog2(A)+1, bits per symbol (localparam)
J_WIDTH, $clog2(J)+1, width of a position index (localparam)
TIMEOUT, 4096, maximum cycles from gen_start to job completion before abort

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_x_initial  in  J*AWIDTH  initial symbol vector; symbol k is at bits [k*AWIDTH +: AWIDTH]
cfg_valid  in  1  cfg_x_initial is valid
cfg_ready  out  1  high only in IDLE
cfg_err  out  1  one-cycle pulse when a vector is rejected
abort  in  1  stop the sweep
sink_ready  in  1  downstream can accept the next job's rows
gen_x_initial  out  J*AWIDTH  registered copy of the accepted vector
gen_x_initial_tvalid  out  1  one-cycle load strobe to the generator
gen_start  out  1  one-cycle job start strobe
gen_j_index  out  J_WIDTH  position of the current job
gen_a_value  out  AWIDTH  symbol value of the current job
gen_row_tvalid  in  1  generator row-valid
gen_row_tlast  in  1  generator last-row flag
job_rows  out  16  number of rows in the last completed job, saturating
job_cnt  out  16  number of jobs completed in the current sweep
busy  out  1  high in every state except IDLE
sweep_done  out  1  one-cycle pulse on normal sweep completion
err_timeout  out  1  sticky; cleared on the next accepted cfg

Behaviour:
- rst_n low: state=IDLE immediately (asynchronous). All outputs 0 except cfg_ready=1. Internal j, a and counters are 0.
- All outputs are registered. No output depends combinationally on an input.
- IDLE:
  - On cfg_valid && cfg_ready, check every symbol is < A.
  - If any symbol is >= A: pulse cfg_err, stay in IDLE, capture nothing.
  - Otherwise: capture the vector into gen_x_initial, clear job_cnt and err_timeout, set j=0, a=0, go to LOAD.
- LOAD: gen_x_initial_tvalid=1 for exactly one cycle, then go to SEEK.
- SEEK (one cycle per candidate pair):
  - If a == x_init[j], advance the pair.
  - Otherwise go to ISSUE.
  - Advance rule: a = a+1; if a wraps past A-1, then a=0 and j=j+1.
  - If j reaches J, go to DONE.
- ISSUE: wait for sink_ready. Then assert gen_start=1 for one cycle with gen_j_index=j and gen_a_value=a held stable, clear the row and timeout counters, and go to STREAM.
- STREAM:
  - Count every cycle with gen_row_tvalid=1 into the row counter.
  - Job is complete at the first cycle where gen_row_tvalid falls 1→0 after gen_start.
  - On completion: latch job_rows, increment job_cnt, advance the pair, go to SEEK.
  - gen_row_tlast is monitored only. A job that completes without having seen tlast still completes normally.
- Timeout: if TIMEOUT cycles elapse in STREAM without completion, set err_timeout and go to DRAIN.
- DONE: pulse sweep_done for one cycle, go to IDLE.
- Abort:
  - abort in LOAD, SEEK or ISSUE: go to IDLE next cycle; no further gen_start; sweep_done not pulsed.
  - abort in STREAM: go to DRAIN.
- DRAIN:
  - Wait until gen_row_tvalid=0 on two consecutive cycles, then go to IDLE without pulsing sweep_done.
  - abort is ignored while in DRAIN.
- Simultaneous events:
  - abort in the same cycle as job completion: abort wins and the FSM goes to DRAIN; job_cnt is still incremented.
  - cfg_valid outside IDLE is ignored and the vector is not captured.
- Job count: a sweep with a valid vector issues exactly J*(A-1) jobs. Order is j ascending (outer loop), then a ascending (inner loop).

Test Plan:
- J=4, A=3, cfg = all 0, sink_ready=1, generator model with 5 rows per job → gen_start pairs (0,1),(0,2),(1,1),(1,2),(2,1),(2,2),(3,1),(3,2); job_cnt=8; job_rows=5; one sweep_done pulse.
- J=4, A=3, cfg = {2,1,0,2} (j=0..3) → pairs (0,0),(0,1),(1,0),(1,2),(2,1),(2,2),(3,0),(3,1); no pair with a == x_init[j].
- cfg with symbol 3 when A=3 → cfg_err pulses once; state stays IDLE; busy=0; no gen_x_initial_tvalid.
- sink_ready held 0 for 20 cycles in ISSUE → no gen_start; gen_j_index and gen_a_value stable; gen_start asserted 1 cycle after sink_ready rises.
- abort during the 3rd job's stream → no new gen_start; state leaves DRAIN 2 cycles after tvalid falls; job_cnt=2 (3 if tvalid falls in the abort cycle); sweep_done=0.
- TIMEOUT=16 with the generator tvalid stuck at 1 → err_timeout=1 at cycle 16 after gen_start; DRAIN until tvalid=0; err_timeout cleared by the next valid cfg; rst_n asserted mid-STREAM → all outputs at reset values immediately.
